// File: rtl/line_clear_ctrl_pkg.sv
// Shared constants and state encoding for the line-clear sequencer.
package line_clear_ctrl_pkg;

  localparam int MAP_COLS = 10;
  localparam int MAP_ROWS = 20;
  localparam int ROW_W    = 5;
  localparam int COL_W    = 4;
  localparam int CELL_W   = 3;

  localparam logic [CELL_W-1:0] CELL_EMPTY = 3'd0;

  typedef enum logic [2:0] {
    LC_IDLE,
    LC_SCAN,
    LC_FLASH,
    LC_COLLAPSE,
    LC_DONE
  } lc_state_t;

endpackage

// File: rtl/line_clear_ctrl_flash_timer.sv
// Flash phase timer: alternating on/off phases of FLASH_CYCLES each, starting on.
// Counters sit at zero whenever run is low, so every run starts a fresh sequence.
module flash_timer #(
  parameter int FLASH_CYCLES = 6250000,
  parameter int FLASH_PHASES = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic flash_on,
  output logic finished
);

  localparam int CNT_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam int PH_W  = $clog2(FLASH_PHASES + 1);

  logic [CNT_W-1:0] cyc_reg;
  logic [PH_W-1:0]  phase_reg;
  logic             phase_end;

  assign phase_end = (cyc_reg == CNT_W'(FLASH_CYCLES - 1));
  assign finished  = run && phase_end && (phase_reg == PH_W'(FLASH_PHASES - 1));
  assign flash_on  = run && !phase_reg[0];

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cyc_reg   <= '0;
      phase_reg <= '0;
    end else if (phase_end) begin
      cyc_reg   <= '0;
      phase_reg <= phase_reg + PH_W'(1);
    end else begin
      cyc_reg   <= cyc_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans the playfield for full rows, flashes them, then
// collapses the map downward through the game-side map RAM port.
module line_clear_ctrl
  import line_clear_ctrl_pkg::*;
#(
  parameter int COLS         = MAP_COLS,
  parameter int ROWS         = MAP_ROWS,
  parameter int FLASH_CYCLES = 6250000,
  parameter int FLASH_PHASES = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [4:0]        lines_cleared,
  output logic [ROWS-1:0]   flash_row_mask,
  output logic              flash_on,
  output logic [4:0]        map_rd_row,
  output logic [3:0]        map_rd_col,
  input  logic [2:0]        map_rd_data,
  output logic              map_we,
  output logic [4:0]        map_wr_row,
  output logic [3:0]        map_wr_col,
  output logic [2:0]        map_wr_data
);

  lc_state_t state_reg, state_next;

  logic [ROW_W-1:0]  scan_row_reg, chk_row_reg, dst_reg, wr_row_reg, lines_reg;
  logic [COL_W-1:0]  scan_col_reg, chk_col_reg, ccol_reg, wr_col_reg;
  logic              issue_done_reg, chk_valid_reg, row_ok_reg;
  logic              last_reg, wr_pending_reg, wr_zero_reg;
  logic [ROWS-1:0]   mask_reg, mask_now;
  logic signed [ROW_W:0] src_reg;

  logic cell_ok, row_ok_now, scan_last, row_skip, row_end;
  logic timer_on, flash_finished;

  // Largest non-full row at or above index 'from'; -1 once the map is exhausted.
  function automatic logic signed [ROW_W:0] next_src(input int from, input logic [ROWS-1:0] m);
    logic signed [ROW_W:0] res;
    res = '1;
    for (int r = 0; r < ROWS; r++)
      if (r <= from && !m[r]) res = (ROW_W+1)'(r);
    return res;
  endfunction

  function automatic logic [ROW_W-1:0] popcount(input logic [ROWS-1:0] m);
    logic [ROW_W-1:0] n;
    n = '0;
    for (int r = 0; r < ROWS; r++) n = n + ROW_W'(m[r]);
    return n;
  endfunction

  assign cell_ok    = (map_rd_data != CELL_EMPTY);
  assign row_ok_now = (chk_col_reg == '0) ? cell_ok : (row_ok_reg && cell_ok);
  assign scan_last  = (state_reg == LC_SCAN) && chk_valid_reg &&
                      (chk_row_reg == ROW_W'(ROWS - 1)) && (chk_col_reg == COL_W'(COLS - 1));

  // A row's mask bit resolves when its last column's data returns.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_mask
    assign mask_now[gi] = (chk_valid_reg && (chk_col_reg == COL_W'(COLS - 1)) &&
                           (chk_row_reg == ROW_W'(gi))) ? row_ok_now : mask_reg[gi];
  end

  assign row_skip = (src_reg == $signed({1'b0, dst_reg}));
  assign row_end  = row_skip || (ccol_reg == COL_W'(COLS - 1));

  flash_timer #(
    .FLASH_CYCLES(FLASH_CYCLES),
    .FLASH_PHASES(FLASH_PHASES)
  ) u_flash_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (state_reg == LC_FLASH),
    .flash_on(timer_on),
    .finished(flash_finished)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= LC_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    busy           = (state_reg != LC_IDLE);
    done           = (state_reg == LC_DONE);
    lines_cleared  = lines_reg;
    flash_row_mask = (state_reg == LC_FLASH) ? mask_reg : '0;
    flash_on       = timer_on;
    map_rd_row     = '0;
    map_rd_col     = '0;
    map_we         = wr_pending_reg;
    map_wr_row     = wr_pending_reg ? wr_row_reg : '0;
    map_wr_col     = wr_pending_reg ? wr_col_reg : '0;
    map_wr_data    = (wr_pending_reg && !wr_zero_reg) ? map_rd_data : CELL_EMPTY;

    if (state_reg == LC_SCAN) begin
      map_rd_row = scan_row_reg;
      map_rd_col = scan_col_reg;
    end else if (state_reg == LC_COLLAPSE && !last_reg && !row_skip && !src_reg[ROW_W]) begin
      map_rd_row = src_reg[ROW_W-1:0];
      map_rd_col = ccol_reg;
    end

    case (state_reg)
      LC_IDLE:     if (start) state_next = LC_SCAN;
      LC_SCAN:     if (scan_last) state_next = (mask_now == '0) ? LC_DONE : LC_FLASH;
      LC_FLASH:    if (flash_finished) state_next = LC_COLLAPSE;
      LC_COLLAPSE: if (last_reg) state_next = LC_DONE;
      LC_DONE:     state_next = LC_IDLE;
      default:     state_next = LC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_row_reg   <= '0;
      scan_col_reg   <= '0;
      issue_done_reg <= 1'b0;
      chk_valid_reg  <= 1'b0;
      chk_row_reg    <= '0;
      chk_col_reg    <= '0;
      row_ok_reg     <= 1'b0;
      mask_reg       <= '0;
      lines_reg      <= '0;
      dst_reg        <= '0;
      src_reg        <= '0;
      ccol_reg       <= '0;
      last_reg       <= 1'b0;
      wr_pending_reg <= 1'b0;
      wr_row_reg     <= '0;
      wr_col_reg     <= '0;
      wr_zero_reg    <= 1'b0;
    end else begin
      wr_pending_reg <= 1'b0;
      case (state_reg)
        LC_IDLE: begin
          if (start) begin
            lines_reg      <= '0;
            mask_reg       <= '0;
            scan_row_reg   <= '0;
            scan_col_reg   <= '0;
            issue_done_reg <= 1'b0;
            chk_valid_reg  <= 1'b0;
          end
        end
        LC_SCAN: begin
          if (!issue_done_reg) begin
            chk_valid_reg <= 1'b1;
            chk_row_reg   <= scan_row_reg;
            chk_col_reg   <= scan_col_reg;
            if (scan_col_reg == COL_W'(COLS - 1)) begin
              scan_col_reg <= '0;
              if (scan_row_reg == ROW_W'(ROWS - 1)) issue_done_reg <= 1'b1;
              else scan_row_reg <= scan_row_reg + ROW_W'(1);
            end else begin
              scan_col_reg <= scan_col_reg + COL_W'(1);
            end
          end else begin
            chk_valid_reg <= 1'b0;
          end
          if (chk_valid_reg) row_ok_reg <= row_ok_now;
          mask_reg <= mask_now;
          if (scan_last) lines_reg <= popcount(mask_now);
        end
        LC_FLASH: begin
          if (flash_finished) begin
            dst_reg  <= ROW_W'(ROWS - 1);
            src_reg  <= next_src(ROWS - 1, mask_reg);
            ccol_reg <= '0;
            last_reg <= 1'b0;
          end
        end
        LC_COLLAPSE: begin
          if (!last_reg) begin
            // Issue stage; the write lands one cycle later with the read data.
            if (!row_skip) begin
              wr_pending_reg <= 1'b1;
              wr_row_reg     <= dst_reg;
              wr_col_reg     <= ccol_reg;
              wr_zero_reg    <= src_reg[ROW_W];
              ccol_reg       <= row_end ? '0 : ccol_reg + COL_W'(1);
            end
            if (row_end) begin
              if (dst_reg == '0) begin
                last_reg <= 1'b1;
              end else begin
                dst_reg <= dst_reg - ROW_W'(1);
                src_reg <= next_src(int'(src_reg) - 1, mask_reg);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: table-driven directed maps, random maps against a
// row-compaction reference model, plus restart and reset corner sequences.
module tb_line_clear_ctrl;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int FC   = 4;
  localparam int FP   = 6;

  logic clk = 1'b0;
  logic rst, start, load;
  logic busy, done, flash_on, map_we;
  logic [4:0] lines_cleared, map_rd_row, map_wr_row;
  logic [3:0] map_rd_col, map_wr_col;
  logic [2:0] map_rd_data, map_wr_data;
  logic [ROWS-1:0] flash_row_mask;

  int total = 0;
  int bad   = 0;

  logic [2:0] mem      [ROWS][COLS];
  logic [2:0] init_map [ROWS][COLS];

  bit mon_on, mon_clr;
  int wr_cnt [ROWS];
  int stray_wr, done_cnt, flash_cyc, flash_bad;
  logic [ROWS-1:0] flash_seen;

  typedef struct {
    int              id;
    logic [ROWS-1:0] exp_mask;
    int              exp_lines;
    int              extra_start;
    bit              chk_lat;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  line_clear_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .FLASH_CYCLES(FC), .FLASH_PHASES(FP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .flash_row_mask(flash_row_mask), .flash_on(flash_on),
    .map_rd_row(map_rd_row), .map_rd_col(map_rd_col), .map_rd_data(map_rd_data),
    .map_we(map_we), .map_wr_row(map_wr_row), .map_wr_col(map_wr_col),
    .map_wr_data(map_wr_data)
  );

  // Map RAM model with one-cycle read latency.
  always @(posedge clk) begin
    if (load) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) mem[r][c] <= init_map[r][c];
    end else if (map_we && map_wr_row < ROWS && map_wr_col < COLS) begin
      mem[map_wr_row][map_wr_col] <= map_wr_data;
    end
    if (map_rd_row < ROWS && map_rd_col < COLS) map_rd_data <= mem[map_rd_row][map_rd_col];
    else map_rd_data <= 3'd0;
  end

  always @(negedge clk) begin
    if (mon_clr) begin
      for (int r = 0; r < ROWS; r++) wr_cnt[r] = 0;
      stray_wr = 0; done_cnt = 0; flash_cyc = 0; flash_bad = 0; flash_seen = '0;
    end else if (mon_on) begin
      if (done) done_cnt++;
      if (map_we) begin
        if (map_wr_row < ROWS) wr_cnt[map_wr_row]++;
        else stray_wr++;
      end
      if (flash_row_mask != '0) begin
        flash_seen = flash_row_mask;
        if (flash_cyc >= FC * FP || flash_on !== (((flash_cyc / FC) % 2) == 0)) flash_bad++;
        flash_cyc++;
      end else if (flash_on !== 1'b0) begin
        flash_bad++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [ROWS-1:0] model_full();
    logic [ROWS-1:0] f;
    for (int r = 0; r < ROWS; r++) begin
      f[r] = 1'b1;
      for (int c = 0; c < COLS; c++) if (init_map[r][c] == 3'd0) f[r] = 1'b0;
    end
    return f;
  endfunction

  task automatic clear_init();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) init_map[r][c] = 3'd0;
  endtask

  task automatic fill_row(input int r);
    for (int c = 0; c < COLS; c++) init_map[r][c] = 3'((c % 7) + 1);
  endtask

  task automatic build_map(input int id);
    clear_init();
    case (id)
      1: begin
        for (int c = 0; c < COLS; c++) init_map[19][c] = 3'd2;
        init_map[18][0] = 3'd3; init_map[18][1] = 3'd3;
        init_map[17][0] = 3'd5;
      end
      2: begin
        fill_row(16); fill_row(18);
        init_map[19][0] = 3'd1;
        init_map[17][0] = 3'd4; init_map[17][1] = 3'd4;
        init_map[15][0] = 3'd6;
      end
      3: begin
        for (int r = 16; r < 20; r++) fill_row(r);
        init_map[15][0] = 3'd7; init_map[15][1] = 3'd7;
      end
      4: begin
        fill_row(0);
        for (int r = 1; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) init_map[r][c] = 3'((r + c) % 8);
      end
      5: begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) init_map[r][c] = 3'(((r * 3 + c) % 7) + 1);
      end
      default: ;
    endcase
  endtask

  task automatic start_run();
    load = 1'b1; mon_clr = 1'b1;
    tick();
    load = 1'b0; mon_clr = 1'b0; mon_on = 1'b1;
    start = 1'b1;
  endtask

  task automatic run_case(input string name, input logic [ROWS-1:0] exp_mask,
                          input int exp_lines, input int extra_start, input bit chk_lat);
    logic [ROWS-1:0] full;
    int keep [$];
    logic [2:0] exp_map [ROWS][COLS];
    int cyc, bad_rows, first_bad, bad_wr;
    bit got_done;

    // Reference: surviving rows keep their order and sink to the bottom.
    full = model_full();
    for (int r = ROWS - 1; r >= 0; r--) if (!full[r]) keep.push_back(r);
    for (int d = ROWS - 1; d >= 0; d--)
      for (int c = 0; c < COLS; c++)
        exp_map[d][c] = (ROWS - 1 - d < keep.size()) ? init_map[keep[ROWS-1-d]][c] : 3'd0;

    start_run();
    cyc = 0; got_done = 1'b0;
    while (cyc < 5000 && !got_done) begin
      tick();
      cyc++;
      start = (cyc == extra_start);
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    check({name, "_done_seen"}, 64'(got_done), 64'd1);
    if (chk_lat) check({name, "_latency"}, 64'(cyc), 64'(ROWS * COLS + 2));
    check({name, "_lines"}, 64'(lines_cleared), 64'(exp_lines));
    tick();
    check({name, "_idle_after"}, {62'd0, busy, done}, 64'd0);
    if (extra_start > 0) repeat (300) tick();
    mon_on = 1'b0;
    check({name, "_done_count"}, 64'(done_cnt), 64'd1);
    check({name, "_flash_mask"}, 64'(flash_seen), 64'(exp_mask));
    check({name, "_flash_cycles"}, 64'(flash_cyc), (exp_mask != '0) ? 64'(FC * FP) : 64'd0);
    check({name, "_flash_pattern"}, 64'(flash_bad), 64'd0);
    check({name, "_stray_writes"}, 64'(stray_wr), 64'd0);

    bad_rows = 0; first_bad = -1; bad_wr = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++)
        if (mem[r][c] !== exp_map[r][c]) begin
          if (first_bad < 0) first_bad = r;
          bad_rows++;
          break;
        end
      // Rows below every full row stay in place and must not be rewritten.
      if (wr_cnt[r] != (((full >> r) != '0) ? COLS : 0)) bad_wr++;
    end
    check({name, "_map_bad_rows(first)"}, {32'(first_bad), 32'(bad_rows)}, {32'hFFFF_FFFF, 32'd0});
    check({name, "_write_rows"}, 64'(bad_wr), 64'd0);
    $display("run %s: lines=%0d mask=%05h cycles=%0d", name, lines_cleared, flash_seen, cyc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load = 1'b0; mon_on = 1'b0; mon_clr = 1'b0;
    clear_init();
    repeat (3) tick();
    check("reset_outputs",
          64'({busy, done, lines_cleared, flash_row_mask, flash_on, map_we,
               map_rd_row, map_rd_col, map_wr_row, map_wr_col, map_wr_data}), 64'd0);
    rst = 1'b0;
    tick();

    vecs[0] = '{0, 20'h00000, 0,  0,   1'b1};
    vecs[1] = '{1, 20'h80000, 1,  0,   1'b0};
    vecs[2] = '{2, 20'h50000, 2,  0,   1'b0};
    vecs[3] = '{3, 20'hF0000, 4,  0,   1'b0};
    vecs[4] = '{4, 20'h00001, 1,  0,   1'b0};
    vecs[5] = '{5, 20'hFFFFF, 20, 0,   1'b0};
    vecs[6] = '{1, 20'h80000, 1,  210, 1'b0};
    vecs[7] = '{0, 20'h00000, 0,  100, 1'b1};

    for (int i = 0; i < 8; i++) begin
      build_map(vecs[i].id);
      run_case($sformatf("vec%0d", i), vecs[i].exp_mask, vecs[i].exp_lines,
               vecs[i].extra_start, vecs[i].chk_lat);
    end

    for (int n = 0; n < 6; n++) begin
      logic [ROWS-1:0] f;
      for (int r = 0; r < ROWS; r++) begin
        if ($urandom_range(0, 3) == 0) begin
          for (int c = 0; c < COLS; c++) init_map[r][c] = 3'($urandom_range(1, 7));
        end else begin
          for (int c = 0; c < COLS; c++) init_map[r][c] = 3'($urandom_range(0, 7));
          init_map[r][$urandom_range(0, COLS - 1)] = 3'd0;
        end
      end
      f = model_full();
      run_case($sformatf("rand%0d", n), f, $countones(f), 0, 1'b0);
    end

    // Reset while collapsing.
    begin
      int cyc;
      build_map(3);
      start_run();
      cyc = 0;
      tick();
      start = 1'b0;
      while (cyc < 2000 && !map_we) begin
        tick();
        cyc++;
      end
      mon_on = 1'b0;
      check("rst_reached_collapse", 64'(map_we), 64'd1);
      check("rst_lines_before", 64'(lines_cleared), 64'd4);
      rst = 1'b1;
      tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_map_we", 64'(map_we), 64'd0);
      check("rst_flash_on", 64'(flash_on), 64'd0);
      check("rst_lines", 64'(lines_cleared), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      rst = 1'b0;
      tick();
    end

    build_map(1);
    run_case("after_rst", 20'h80000, 1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_clear_ctrl.md
Name: line_clear_ctrl

Overview:
- Sequences the playfield map after every piece lock: scans for full rows, drives the row-flash overlay for the display colour mux, then collapses the map downward and reports how many lines were cleared.
- While busy it exclusively owns the game-side port of the dual-port map RAM; the display read port is unaffected.
- Sits between the piece/lock controller (start, busy, done) and the map RAM.
- Its flash outputs feed the display colour mux, which forces `BLACK` on flashing rows.

Parameters:
- COLS, 10, map width in cells
- ROWS, 20, map height in cells (row 0 = top)
- FLASH_CYCLES, 6250000, clk cycles per flash phase
- FLASH_PHASES, 6, number of flash phases (on/off alternating, starting on)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse after a piece locks; ignored unless IDLE
- busy  out  1  high from the cycle after an accepted start through the DONE cycle; grants the map port to this block
- done  out  1  one-cycle pulse at completion
- lines_cleared  out  5  full rows removed by the last run; held until the next accepted start
- flash_row_mask  out  ROWS  bit r set = row r is full; valid during FLASH, 0 otherwise
- flash_on  out  1  flash phase is "on"; display blacks out masked rows
- map_rd_row  out  5  read address, row
- map_rd_col  out  4  read address, column
- map_rd_data  in  3  cell type; 0 = empty, 1..7 = block type; one-cycle read latency
- map_we  out  1  write enable
- map_wr_row  out  5  write address, row
- map_wr_col  out  4  write address, column
- map_wr_data  out  3  write data

Behaviour:
- Reset values: busy=0, done=0, lines_cleared=0, flash_row_mask=0, flash_on=0, map_we=0, all addresses/data=0, state=IDLE.
- rst mid-operation: next cycle all outputs return to reset values; partial map edits are not undone.
- IDLE:
  - start=1 → SCAN, clears lines_cleared and the internal mask.
  - start while not IDLE is dropped (no queuing).
- SCAN:
  - Issues one read per cycle in row-major order, (0,0) to (ROWS-1,COLS-1).
  - Data is checked one cycle later; a row is full iff all COLS cells are nonzero; mask bit set after its last column returns.
  - Duration is ROWS*COLS+1 cycles.
  - Mask==0 → DONE. Otherwise lines_cleared=popcount(mask) → FLASH.
- FLASH:
  - flash_row_mask=mask.
  - flash_on=1 for the first phase and toggles at each phase boundary; each phase lasts FLASH_CYCLES.
  - After FLASH_PHASES phases: flash_on=0, mask output 0 → COLLAPSE.
- COLLAPSE:
  - Pointers: dst=ROWS-1; src=ROWS-1, decremented past every masked row.
  - For each dst from ROWS-1 down to 0:
    - src==dst: no reads or writes for this row.
    - src valid and <dst: read (src,c) for c=0..COLS-1; write (dst,c) with the returned data one cycle later. Pipelined at 1 cell/cycle; read and write rows are always distinct, so there is no hazard.
    - src exhausted (<0): write 0 to (dst,c) for all c.
  - Then dst--, src-- and skip masked rows again.
  - After dst=0 and the final write drains → DONE.
- DONE: done=1 for one cycle, busy=1 this cycle; next cycle IDLE with busy=0.
- map_we is only ever asserted in COLLAPSE.
- Read addresses are don't-care outside SCAN and COLLAPSE; they are held at 0.

Decomposition:
- global.v constants: `MAP_COLS, `MAP_ROWS, `CELL_EMPTY (3'd0), state encodings `LC_IDLE/`LC_SCAN/`LC_FLASH/`LC_COLLAPSE/`LC_DONE.
- One sub-module, flash_timer: phase counter plus toggle.
  - Inputs: clk, rst, run.
  - Outputs: flash_on, finished.
  - Parameters: FLASH_CYCLES, FLASH_PHASES.

Test Plan (FLASH_CYCLES=4 in sim):
- Empty map, start → no map_we ever, no flash; done pulses exactly ROWS*COLS+2 cycles after start; lines_cleared=0.
- Row 19 full (type 2); row 18 = {3,3,0...}; row 17 = {5,0...} → flash_row_mask=20'h80000; flash_on pattern 1,0,1,0,1,0 with 4 cycles each. Final map: row19={3,3,0...}, row18={5,0...}, row0 all 0; lines_cleared=1.
- Rows 16 and 18 full; row 19 = {1,0...}; row 17 = {4,...}; row 15 = {6,...} → zero writes to row 19; final row18=old17, row17=old15, rows 0-1 zeroed; lines_cleared=2.
- Rows 16-19 full, row 15 = {7,7,...} → row19=old15, rows 0-3 all 0; lines_cleared=4.
- Only row 0 full → row 0 written to 0, rows 1-19 untouched (no writes); lines_cleared=1.
- Second start pulse during FLASH is ignored and produces a single done. Separately, rst asserted during COLLAPSE → next cycle busy=0, map_we=0, flash_on=0, lines_cleared=0.
